// File: rtl/aib_sr_sl_rx.sv
// AIB sideband shift-register receiver, master-to-slave: deserialize, length-check, debounce control bits.
// Optional watchdog on missing frames is compiled in with `define SR_RX_TIMEOUT_EN.
module aib_sr_sl_rx #(
   parameter int SR_LEN          = 81,
   parameter int FILTER_CNT      = 2,
   parameter int BIT_OSC_EN      = 0,
   parameter int BIT_OSC_ALIVE   = 1,
   parameter int BIT_TX_CAL_DONE = 2,
   parameter int BIT_TX_XFER_EN  = 3,
   parameter int BIT_RX_DLL_LOCK = 4,
   parameter int BIT_RX_XFER_EN  = 5,
   parameter int TIMEOUT_CYC     = 1024
) (
   input  logic              sr_ms_clk_in,
   input  logic              reset,
   input  logic              sr_ms_data_in,
   input  logic              sr_ms_load_in,
   output logic [SR_LEN-1:0] frame_data,
   output logic              frame_valid,
   output logic              frame_err,
   output logic [7:0]        err_cnt,
   output logic              ms_osc_transfer_eni,
   output logic              ms_osc_transfer_alivei,
   output logic              ms_tx_dcc_cal_donei,
   output logic              ms_tx_transfer_eni,
   output logic              ms_rx_dll_locki,
   output logic              ms_rx_transfer_eni,
   output logic              sr_timeout
);

   localparam int CW = $clog2(SR_LEN + 2);
   localparam int MW = $clog2(FILTER_CNT + 1);
   localparam logic [CW-1:0] LEN_C = CW'(SR_LEN);
   localparam logic [CW-1:0] SAT_C = CW'(SR_LEN + 1);
   localparam logic [MW-1:0] FC_C  = MW'(FILTER_CNT);

   logic [SR_LEN-1:0] shift_q, shift_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [SR_LEN-1:0] frame_data_q, frame_data_d;
   logic              frame_valid_q, frame_valid_d;
   logic              frame_err_q, frame_err_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic [5:0]        cand_q, cand_d;
   logic [MW-1:0]     match_q, match_d;
   logic              upd_q, upd_d;
   logic [5:0]        ctrl_q, ctrl_d;
   logic [5:0]        vec;

   function automatic logic [5:0] ctrl_vec(input logic [SR_LEN-1:0] f);
      return {f[BIT_RX_XFER_EN], f[BIT_RX_DLL_LOCK], f[BIT_TX_XFER_EN],
              f[BIT_TX_CAL_DONE], f[BIT_OSC_ALIVE], f[BIT_OSC_EN]};
   endfunction

`ifdef SR_RX_TIMEOUT_EN
   localparam logic [15:0] TO_C = 16'(TIMEOUT_CYC);
   logic [15:0] to_cnt_q, to_cnt_d;
   logic        sr_timeout_q, sr_timeout_d;
`endif

   always_comb begin
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      frame_data_d  = frame_data_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      err_cnt_d     = err_cnt_q;
      cand_d        = cand_q;
      match_d       = match_q;
      upd_d         = 1'b0;
      ctrl_d        = ctrl_q;
      vec           = ctrl_vec(frame_data_q);

      // Load-cycle data is not part of the frame; the length is judged on the count before this edge.
      if (sr_ms_load_in) begin
         bit_cnt_d = '0;
         if (bit_cnt_q == LEN_C) begin
            frame_valid_d = 1'b1;
            frame_data_d  = shift_q;
            if (FILTER_CNT == 1) ctrl_d = ctrl_vec(shift_q);
         end else begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
         end
      end else begin
         shift_d = {shift_q[SR_LEN-2:0], sr_ms_data_in};
         if (bit_cnt_q != SAT_C) bit_cnt_d = bit_cnt_q + 1'b1;
      end

      // Filter runs one clock behind the load, outputs follow one clock after the match completes.
      if (frame_valid_q) begin
         if (vec == cand_q) begin
            if (match_q != FC_C) match_d = match_q + 1'b1;
         end else begin
            cand_d  = vec;
            match_d = MW'(1);
         end
         upd_d = (FILTER_CNT > 1) && (match_d == FC_C);
      end else if (frame_err_q) begin
         match_d = '0;
      end

      if (upd_q) ctrl_d = cand_q;

`ifdef SR_RX_TIMEOUT_EN
      if (frame_valid_d)        to_cnt_d = '0;
      else if (to_cnt_q == TO_C) to_cnt_d = to_cnt_q;
      else                      to_cnt_d = to_cnt_q + 16'd1;
      sr_timeout_d = !frame_valid_d && (to_cnt_d == TO_C);
      if (sr_timeout_d) begin
         ctrl_d  = '0;
         match_d = '0;
         upd_d   = 1'b0;
      end
`endif
   end

   always_ff @(posedge sr_ms_clk_in or posedge reset) begin
      if (reset) begin
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         err_cnt_q     <= '0;
         cand_q        <= '0;
         match_q       <= '0;
         upd_q         <= 1'b0;
         ctrl_q        <= '0;
      end else begin
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         frame_data_q  <= frame_data_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         err_cnt_q     <= err_cnt_d;
         cand_q        <= cand_d;
         match_q       <= match_d;
         upd_q         <= upd_d;
         ctrl_q        <= ctrl_d;
      end
   end

`ifdef SR_RX_TIMEOUT_EN
   always_ff @(posedge sr_ms_clk_in or posedge reset) begin
      if (reset) begin
         to_cnt_q     <= '0;
         sr_timeout_q <= 1'b0;
      end else begin
         to_cnt_q     <= to_cnt_d;
         sr_timeout_q <= sr_timeout_d;
      end
   end
   assign sr_timeout = sr_timeout_q;
`else
   assign sr_timeout = 1'b0;
`endif

   assign frame_data             = frame_data_q;
   assign frame_valid            = frame_valid_q;
   assign frame_err              = frame_err_q;
   assign err_cnt                = err_cnt_q;
   assign ms_osc_transfer_eni    = ctrl_q[0];
   assign ms_osc_transfer_alivei = ctrl_q[1];
   assign ms_tx_dcc_cal_donei    = ctrl_q[2];
   assign ms_tx_transfer_eni     = ctrl_q[3];
   assign ms_rx_dll_locki        = ctrl_q[4];
   assign ms_rx_transfer_eni     = ctrl_q[5];

endmodule
